// File: rtl/pulse_pkg.sv
// Shared types and default widths for the pulse discriminator and the event packer.
package pulse_pkg;

   localparam int unsigned DEF_DATA_W  = 14;
   localparam int unsigned DEF_TOT_W   = 12;
   localparam int unsigned DEF_TS_W    = 32;
   localparam int unsigned DEF_HOLDOFF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   // Event payload as seen by the event packer (default widths).
   typedef struct packed {
      logic [DEF_DATA_W-1:0] peak;
      logic [DEF_TOT_W-1:0]  tot;
      logic [DEF_TS_W-1:0]   ts;
   } pulse_evt_t;

endpackage

// File: rtl/pulse_evt_slot.sv
// Single-entry registered valid/ready output slot; reports events lost to a full slot.
module pulse_evt_slot #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data,
   output logic         drop_c
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         accept;

   // A slot being drained this cycle can take a new event in the same cycle.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      drop_c  = 1'b0;
      accept  = valid_q && ready;
      if (load && (!valid_q || accept)) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else begin
         if (load) drop_c = 1'b1;
         if (accept) valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/pulse_peak_detector.sv
// Threshold/hysteresis pulse discriminator with holdoff; emits peak, ToT and crossing timestamp.
module pulse_peak_detector
   import pulse_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned TOT_W   = DEF_TOT_W,
   parameter int unsigned TS_W    = DEF_TS_W,
   parameter int unsigned HOLDOFF = DEF_HOLDOFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample,
   input  logic [DATA_W-1:0] threshold,
   input  logic [DATA_W-1:0] hysteresis,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [DATA_W-1:0] evt_peak,
   output logic [TOT_W-1:0]  evt_tot,
   output logic [TS_W-1:0]   evt_ts,
   output logic [15:0]       drop_cnt,
   output logic              busy
);

   localparam int unsigned HC_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam int unsigned P_W  = DATA_W + TOT_W + TS_W;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] thr_q, thr_d;
   logic [DATA_W-1:0] hys_q, hys_d;
   logic [DATA_W-1:0] peak_q, peak_d;
   logic [TOT_W-1:0]  tot_q, tot_d;
   logic [TS_W-1:0]   ts_lat_q, ts_lat_d;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic [HC_W-1:0]   hcnt_q, hcnt_d;
   logic [15:0]       drop_q, drop_d;
   logic              busy_q, busy_d;

   logic              offer;
   logic              trail;
   logic              drop_c;
   logic [P_W-1:0]    slot_data;

   // Trailing edge compared one bit wider so sample + hysteresis cannot wrap.
   assign trail = ({1'b0, sample} + {1'b0, hys_q}) < {1'b0, thr_q};

   always_comb begin
      state_d  = state_q;
      thr_d    = thr_q;
      hys_d    = hys_q;
      peak_d   = peak_q;
      tot_d    = tot_q;
      ts_lat_d = ts_lat_q;
      hcnt_d   = hcnt_q;
      drop_d   = drop_q;
      offer    = 1'b0;
      ts_d     = ts_q + TS_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (sample_valid && enable && (sample >= threshold)) begin
               state_d  = ST_PULSE;
               thr_d    = threshold;
               hys_d    = hysteresis;
               peak_d   = sample;
               tot_d    = TOT_W'(1);
               ts_lat_d = ts_q;
            end
         end
         ST_PULSE: begin
            if (sample_valid) begin
               // A full ToT counter ends the pulse even if the sample is still above the trail level.
               if (trail || (tot_q == '1)) begin
                  offer = 1'b1;
                  if (HOLDOFF == 0) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_HOLD;
                     hcnt_d  = HC_W'(HOLDOFF);
                  end
               end else begin
                  if (sample > peak_q) peak_d = sample;
                  tot_d = tot_q + TOT_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (sample_valid) begin
               hcnt_d = hcnt_q - HC_W'(1);
               if (hcnt_q == HC_W'(1)) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (drop_c && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         thr_q    <= '0;
         hys_q    <= '0;
         peak_q   <= '0;
         tot_q    <= '0;
         ts_lat_q <= '0;
         ts_q     <= '0;
         hcnt_q   <= '0;
         drop_q   <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         thr_q    <= thr_d;
         hys_q    <= hys_d;
         peak_q   <= peak_d;
         tot_q    <= tot_d;
         ts_lat_q <= ts_lat_d;
         ts_q     <= ts_d;
         hcnt_q   <= hcnt_d;
         drop_q   <= drop_d;
         busy_q   <= busy_d;
      end
   end

   pulse_evt_slot #(
      .W (P_W)
   ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (offer),
      .load_data ({peak_q, tot_q, ts_lat_q}),
      .ready     (evt_ready),
      .valid     (evt_valid),
      .data      (slot_data),
      .drop_c    (drop_c)
   );

   assign {evt_peak, evt_tot, evt_ts} = slot_data;
   assign drop_cnt = drop_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Randomized and directed checks of pulse_peak_detector against a per-sample behavioural model.
module tb_pulse_peak_detector;

   localparam int unsigned DATA_W  = 14;
   localparam int unsigned TOT_W   = 4;
   localparam int unsigned TS_W    = 32;
   localparam int unsigned HOLDOFF = 8;
   localparam int          TOT_MAX = (1 << TOT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic              sample_valid = 1'b0;
   logic [DATA_W-1:0] sample = '0;
   logic [DATA_W-1:0] threshold = '0;
   logic [DATA_W-1:0] hysteresis = '0;
   logic              evt_valid;
   logic              evt_ready = 1'b0;
   logic [DATA_W-1:0] evt_peak;
   logic [TOT_W-1:0]  evt_tot;
   logic [TS_W-1:0]   evt_ts;
   logic [15:0]       drop_cnt;
   logic              busy;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: 0 idle, 1 in pulse, 2 holdoff
   int          m_mode, m_thr, m_hys, m_peak, m_tot, m_hcnt, m_drop;
   int unsigned m_ts, m_now;
   bit          m_valid;
   int          e_peak, e_tot;
   int unsigned e_ts;

   pulse_peak_detector #(
      .DATA_W  (DATA_W),
      .TOT_W   (TOT_W),
      .TS_W    (TS_W),
      .HOLDOFF (HOLDOFF)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .sample_valid (sample_valid),
      .sample       (sample),
      .threshold    (threshold),
      .hysteresis   (hysteresis),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_peak     (evt_peak),
      .evt_tot      (evt_tot),
      .evt_ts       (evt_ts),
      .drop_cnt     (drop_cnt),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_thr = 0; m_hys = 0; m_peak = 0; m_tot = 0; m_hcnt = 0;
      m_drop = 0; m_ts = 0; m_now = 0; m_valid = 0;
      e_peak = 0; e_tot = 0; e_ts = 0;
   endtask

   // Apply one clock edge worth of the pulse rules to the model.
   task automatic model_edge(input bit v, input int s, input bit en, input bit rdy);
      bit accept;
      bit offer;
      accept = m_valid && rdy;
      offer  = 0;
      if (v) begin
         if (m_mode == 0) begin
            if (en && s >= int'(threshold)) begin
               m_mode = 1; m_thr = int'(threshold); m_hys = int'(hysteresis);
               m_peak = s; m_tot = 1; m_ts = m_now;
            end
         end else if (m_mode == 1) begin
            if ((s + m_hys < m_thr) || m_tot == TOT_MAX) begin
               offer  = 1;
               m_mode = (HOLDOFF == 0) ? 0 : 2;
               m_hcnt = HOLDOFF;
            end else begin
               if (s > m_peak) m_peak = s;
               m_tot++;
            end
         end else begin
            m_hcnt--;
            if (m_hcnt == 0) m_mode = 0;
         end
      end
      if (offer) begin
         if (!m_valid || accept) begin
            m_valid = 1; e_peak = m_peak; e_tot = m_tot; e_ts = m_ts;
         end else if (m_drop < 16'hFFFF) begin
            m_drop++;
         end
      end else if (accept) begin
         m_valid = 0;
      end
      m_now++;
   endtask

   task automatic check_all();
      chk("evt_valid", 64'(evt_valid), 64'(m_valid));
      chk("busy", 64'(busy), 64'(m_mode != 0));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (m_valid) begin
         chk("evt_peak", 64'(evt_peak), 64'(e_peak));
         chk("evt_tot", 64'(evt_tot), 64'(e_tot));
         chk("evt_ts", 64'(evt_ts), 64'(e_ts));
      end
   endtask

   // Called at a negedge: drive inputs, advance model across the next posedge, check at the next negedge.
   task automatic step(input bit v, input int s, input bit en, input bit rdy);
      sample_valid = v;
      sample       = DATA_W'(s);
      enable       = en;
      evt_ready    = rdy;
      model_edge(v, s, en, rdy);
      @(negedge clk);
      check_all();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, 64'(evt_valid), 64'd0);
      chk({tag, "_peak"}, 64'(evt_peak), 64'd0);
      chk({tag, "_tot"}, 64'(evt_tot), 64'd0);
      chk({tag, "_ts"}, 64'(evt_ts), 64'd0);
      chk({tag, "_drop"}, 64'(drop_cnt), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_zero("rst");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 1, 1);
   endtask

   initial begin
      int          s;
      int unsigned ts120;
      model_reset();
      @(negedge clk);
      do_reset();

      // Basic pulse
      threshold = 14'd100; hysteresis = 14'd10;
      step(1, 50, 1, 1);
      ts120 = m_now;
      step(1, 120, 1, 1);
      chk("basic_busy", 64'(busy), 64'd1);
      step(1, 300, 1, 1);
      step(1, 200, 1, 1);
      chk("basic_novalid", 64'(evt_valid), 64'd0);
      step(1, 85, 1, 1);
      chk("basic_valid", 64'(evt_valid), 64'd1);
      chk("basic_peak", 64'(evt_peak), 64'd300);
      chk("basic_tot", 64'(evt_tot), 64'd3);
      chk("basic_ts", 64'(evt_ts), 64'(ts120));
      step(1, 50, 1, 1);
      quiet(HOLDOFF + 2);

      // Backpressure
      step(1, 200, 1, 0); step(1, 250, 1, 0); step(1, 50, 1, 0);
      for (int i = 0; i < HOLDOFF + 1; i++) step(1, 0, 1, 0);
      step(1, 300, 1, 0); step(1, 40, 1, 0);
      for (int i = 0; i < HOLDOFF + 1; i++) step(1, 0, 1, 0);
      chk("bp_drop", 64'(drop_cnt), 64'd1);
      chk("bp_peak", 64'(evt_peak), 64'd250);
      chk("bp_tot", 64'(evt_tot), 64'd2);
      step(1, 0, 1, 1);
      chk("bp_drained", 64'(evt_valid), 64'd0);

      // Holdoff: crossing on the 8th holdoff sample ignored, 9th triggers
      step(1, 150, 1, 1); step(1, 50, 1, 1);
      for (int i = 0; i < HOLDOFF - 1; i++) step(1, 0, 1, 1);
      step(1, 150, 1, 1);
      chk("hold8_idle", 64'(busy), 64'd0);
      step(1, 150, 1, 1);
      chk("hold9_trig", 64'(busy), 64'd1);
      step(1, 50, 1, 1);
      quiet(HOLDOFF + 1);

      // ToT saturation
      for (int i = 1; i <= 25; i++) begin
         step(1, 500, 1, 1);
         if (i == TOT_MAX + 1) begin
            chk("sat_valid", 64'(evt_valid), 64'd1);
            chk("sat_tot", 64'(evt_tot), 64'(TOT_MAX));
            chk("sat_peak", 64'(evt_peak), 64'd500);
         end
         if (i == TOT_MAX + 1 + HOLDOFF) chk("sat_hold_end", 64'(busy), 64'd0);
      end
      chk("sat_retrig", 64'(busy), 64'd1);
      step(1, 0, 1, 1);
      quiet(HOLDOFF + 1);

      // Valid gaps
      step(1, 200, 1, 1); step(0, 4000, 1, 1);
      step(1, 250, 1, 1); step(0, 4000, 1, 1);
      step(1, 220, 1, 1); step(0, 4000, 1, 1);
      step(1, 210, 1, 1); step(0, 4000, 1, 1);
      step(1, 10, 1, 1);
      chk("gap_tot", 64'(evt_tot), 64'd4);
      chk("gap_peak", 64'(evt_peak), 64'd250);
      quiet(HOLDOFF + 1);

      // Reset mid-pulse with a pending event
      step(1, 200, 1, 0); step(1, 20, 1, 0);
      quiet(HOLDOFF);
      step(1, 200, 1, 0); step(1, 300, 1, 0);
      do_reset();
      step(1, 0, 1, 1);
      chk("rst_after_drop", 64'(drop_cnt), 64'd0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            threshold  = DATA_W'($urandom_range(20, 3000));
            hysteresis = DATA_W'($urandom_range(0, 400));
         end
         if ($urandom_range(0, 3) == 0) s = $urandom_range(0, 16383);
         else s = $urandom_range(0, 2 * int'(threshold) + 1);
         step($urandom_range(0, 3) != 0, s, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
